psa_accum: RTL and testbench
============================

PSA_ACCUM -- requirements
Module: psa_accum

Interface
REQ-001 SHALL have no parameters; lane width is fixed at 4 bits, 4 lanes, 16-bit operands.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new accumulation; honoured only in IDLE.
REQ-005 len  input  4  number of operands to accumulate (0-15), sampled with start.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  16  packed operand, four signed 4-bit lanes: [15:12], [11:8], [7:4], [3:0].
REQ-009 out_valid  output  1  sum, lane_ovfl and error are valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 sum  output  16  packed lane-wise accumulated result.
REQ-012 lane_ovfl  output  4  sticky per-lane overflow; bit i covers lane i (bit 0 = [3:0]).
REQ-013 error  output  1  OR of lane_ovfl.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ACC, DONE.
REQ-016 IDLE: in_ready=0, out_valid=0; start with len!=0 -> ACC, accumulator and lane_ovfl cleared, remaining count loaded with len.
REQ-017 IDLE: start with len=0 -> DONE next cycle, sum=16'h0000, lane_ovfl=4'h0.
REQ-018 ACC: in_ready=1; transfer occurs when in_valid and in_ready are both high in the same cycle; cycles with in_valid=0 leave all state unchanged.
REQ-019 Each transfer: each lane i <= lane_add(acc lane i, in_data lane i), two's-complement signed 4-bit arithmetic; remaining decremented.
REQ-020 Lane overflow: operands of equal sign, result of different sign; sets lane_ovfl[i], and the bit stays set until next start or reset.
REQ-021 Default lane_add SHALL saturate: positive overflow -> 4'h7, negative overflow -> 4'h8; subsequent adds continue from the saturated value.
REQ-022 Transfer with remaining==1 SHALL move to DONE; out_valid is high the cycle after the final transfer (latency 1).
REQ-023 DONE: in_ready=0, out_valid=1; sum/lane_ovfl/error held stable while out_ready=0.
REQ-024 DONE with out_ready=1 -> IDLE next cycle; out_valid drops the same edge.
REQ-025 start SHALL be ignored in ACC and DONE, including a start coincident with the DONE handshake.
REQ-026 sum, lane_ovfl, error SHALL reflect the internal registers at all times (no combinational path from in_data to outputs).

Reset
REQ-027 rst high SHALL immediately force IDLE, accumulator=0, remaining=0, lane_ovfl=0; hence sum=0, error=0, out_valid=0, in_ready=0, busy=0.
REQ-028 rst asserted mid-ACC or mid-DONE SHALL discard the partial/pending result; no out_valid pulse follows.
REQ-029 First start after rst deasserts SHALL be honoured on the first rising edge that sees rst low.

Configuration
REQ-030 Macro PSA_ACCUM_WRAP_EN defined: lane_add SHALL wrap modulo 16 instead of saturating; lane_ovfl/error still set per REQ-020.
REQ-031 Macro undefined: saturating behaviour per REQ-021; all other behaviour identical in both builds.

Verification
REQ-032 len=2, in_data 16'h1234 then 16'h1111 -> out_valid 1 cycle after 2nd transfer, sum=16'h2345, lane_ovfl=4'h0, error=0.
REQ-033 len=2, 16'h7777 then 16'h1111 -> sum=16'h7777 (WRAP_EN: 16'h8888), lane_ovfl=4'hF, error=1.
REQ-034 len=2, 16'h8000 then 16'hF000 -> sum=16'h8000 (WRAP_EN: 16'h7000), lane_ovfl=4'b1000.
REQ-035 len=0 start -> DONE next cycle, sum=16'h0000; hold out_ready=0 for 3 cycles -> outputs stable, busy=1; start pulses ignored; out_ready=1 -> IDLE.
REQ-036 len=3 with in_valid gaps (1,0,1,0,1) -> exactly 3 transfers counted; rst pulse mid-ACC -> all outputs 0 asynchronously, next start with len=1 and 16'h0001 -> sum=16'h0001.

Source files
------------

// File: rtl/psa_accum.sv
// psa_accum: four-lane signed 4-bit accumulator with a valid/ready stream
// in and a held result out. Define PSA_ACCUM_WRAP_EN to wrap instead of saturate.
module psa_accum (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [3:0]  len,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] sum,
   output logic [3:0]  lane_ovfl,
   output logic        error,
   output logic        busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [15:0] acc;
   logic [15:0] acc_nxt;
   logic [3:0]  ovfl;
   logic [3:0]  ovfl_nxt;
   logic [3:0]  rem;
   logic [3:0]  rem_nxt;
   logic [15:0] add_res;
   logic [3:0]  add_ov;
   logic        xfer;

   // {overflow, result} of one signed 4-bit lane add
   function automatic logic [4:0] lane_add(
      input logic [3:0] a,
      input logic [3:0] b
   );
      logic [3:0] s;
      logic       ov;
      s  = a + b;
      ov = (a[3] == b[3]) && (s[3] != a[3]);
`ifdef PSA_ACCUM_WRAP_EN
      return {ov, s};
`else
      if (ov)
         return {1'b1, (a[3] ? 4'h8 : 4'h7)};
      else
         return {1'b0, s};
`endif
   endfunction

   assign in_ready  = (state == ACC);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign sum       = acc;
   assign lane_ovfl = ovfl;
   assign error     = |ovfl;
   assign xfer      = in_valid && in_ready;

   // per-lane adder results for the current accumulator and operand
   always_comb begin
      logic [4:0] r;
      add_res = '0;
      add_ov  = '0;
      r       = '0;
      for (int i = 0; i < 4; i++) begin
         r = lane_add(acc[i*4 +: 4], in_data[i*4 +: 4]);
         add_res[i*4 +: 4] = r[3:0];
         add_ov[i]         = r[4];
      end
   end

   // next-state and datapath update selection
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      ovfl_nxt  = ovfl;
      rem_nxt   = rem;
      unique case (state)
         IDLE: begin
            if (start) begin
               acc_nxt   = '0;
               ovfl_nxt  = '0;
               rem_nxt   = len;
               state_nxt = (len == 4'd0) ? DONE : ACC;
            end
         end
         ACC: begin
            if (xfer) begin
               acc_nxt  = add_res;
               ovfl_nxt = ovfl | add_ov;
               rem_nxt  = rem - 4'd1;
               if (rem == 4'd1)
                  state_nxt = DONE;
            end
         end
         DONE: begin
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // state and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         acc   <= '0;
         ovfl  <= '0;
         rem   <= '0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         ovfl  <= ovfl_nxt;
         rem   <= rem_nxt;
      end
   end

endmodule

// File: tb/tb_psa_accum.sv
// tb_psa_accum: directed vectors with a result scoreboard for psa_accum.
// Expected sums follow the build selected by PSA_ACCUM_WRAP_EN.
module tb_psa_accum;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  len;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic [3:0]  lane_ovfl;
   logic        error;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [20:0] sb[$];

   psa_accum dut (
      .clk(clk), .rst(rst), .start(start), .len(len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .lane_ovfl(lane_ovfl), .error(error), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // expected result: {error, lane_ovfl, sum}
   task automatic push(input logic [15:0] s, input logic [3:0] o);
      sb.push_back({|o, o, s});
   endtask

   // scoreboard monitor: compares on each output handshake
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL result unexpected got %h", {error, lane_ovfl, sum});
         end else begin
            logic [20:0] e;
            e = sb.pop_front();
            if ({error, lane_ovfl, sum} !== e) begin
               errors++;
               $display("FAIL result got %h expected %h",
                        {error, lane_ovfl, sum}, e);
            end
         end
      end
   end

   task automatic start_op(input logic [3:0] l);
      start = 1'b1;
      len   = l;
      @(posedge clk);
      #1 start = 1'b0;
      len = 4'd0;
   endtask

   task automatic xfer(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      chk("in_ready", in_ready, 1);
      chk("out_valid_low", out_valid, 0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_data = 16'hFFFF;
   endtask

   task automatic finish_op();
      @(negedge clk);
      chk("latency", out_valid, 1);
      @(posedge clk);
      #1 chk("idle_after", busy, 0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = 4'd0;
      in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_sum", sum, 0);
      chk("rst_busy", busy, 0);
      chk("rst_flags", {out_valid, in_ready, error, lane_ovfl}, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // basic sum, no overflow
      push(16'h2345, 4'h0);
      start_op(4'd2);
      xfer(16'h1234);
      xfer(16'h1111);
      finish_op();

      // positive overflow in every lane
`ifdef PSA_ACCUM_WRAP_EN
      push(16'h8888, 4'hF);
`else
      push(16'h7777, 4'hF);
`endif
      start_op(4'd2);
      xfer(16'h7777);
      xfer(16'h1111);
      finish_op();

      // negative overflow in top lane only
`ifdef PSA_ACCUM_WRAP_EN
      push(16'h7000, 4'h8);
`else
      push(16'h8000, 4'h8);
`endif
      start_op(4'd2);
      xfer(16'h8000);
      xfer(16'hF000);
      finish_op();

      // zero length, held result, ignored starts
      push(16'h0000, 4'h0);
      out_ready = 1'b0;
      start_op(4'd0);
      for (int i = 0; i < 3; i++) begin
         start = 1'b1;
         len   = 4'd5;
         @(negedge clk);
         chk("hold_valid", out_valid, 1);
         chk("hold_busy", busy, 1);
         chk("hold_out", {error, lane_ovfl, sum}, 0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      len = 4'd0;
      chk("done_start_ign", {busy, in_ready, out_valid}, 0);

      // gaps on in_valid: three transfers over five cycles
      push(16'h3333, 4'h0);
      start_op(4'd3);
      for (int i = 0; i < 5; i++) begin
         in_valid = (i % 2 == 0);
         in_data  = in_valid ? 16'h1111 : 16'h7777;
         @(negedge clk);
         chk("gap_ready", in_ready, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("gap_done", out_valid, 1);
      @(posedge clk);
      #1 chk("gap_idle", busy, 0);

      // asynchronous reset mid-accumulation
      start_op(4'd3);
      xfer(16'h7777);
      xfer(16'h1111);
      #2 rst = 1'b1;
      #1;
      chk("arst_sum", sum, 0);
      chk("arst_err", {error, lane_ovfl}, 0);
      chk("arst_ctl", {busy, in_ready, out_valid}, 0);
      #2 rst = 1'b0;
      start = 1'b1;
      len   = 4'd1;
      @(posedge clk);
      #1 start = 1'b0;
      len = 4'd0;
      chk("post_rst_start", busy, 1);
      push(16'h0001, 4'h0);
      xfer(16'h0001);
      finish_op();

      repeat (3) @(posedge clk);
      #1 chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
